// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   UART receiver driven by an oversampled tick (prescale ticks per bit).
//   Recovers DATA_BITS-data-bit frames, LSB first, with an optional parity
//   bit and one stop bit. Each byte is delivered with a one-clk valid strobe
//   together with its parity and framing status.
//
// Ports
//   clk          system clock
//   rst          synchronous active-low reset
//   rx_tick      one-clk oversample enable (prescale x baud)
//   prescale     ticks per bit period, even values 4..254, latched per frame
//   rx_in        asynchronous serial input, idle high
//   data_out     last received word, held until the next frame completes
//   data_valid   one-clk strobe when data_out and the error flags update
//   parity_err   parity mismatch on the last frame (0 when parity disabled)
//   framing_err  stop bit sampled low on the last frame
//   busy         high while a frame is being received
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic [7:0]           prescale,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state, state_nx;
  logic                 rx_m, rx_s;
  logic [1:0]           primed;
  logic [7:0]           cnt, p_lat;
  logic [7:0]           half_m1, full_m1;
  logic [2:0]           bit_cnt;
  logic                 armed;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit, stop_bit;
  logic                 finish;

  logic start_det, shift_en, par_en, stop_en, cnt_inc, cnt_clr;

  assign half_m1 = (p_lat >> 1) - 8'd1;
  assign full_m1 = p_lat - 8'd1;
  assign busy    = (state != IDLE);

  function automatic logic parity_check(input logic [DATA_BITS-1:0] d,
                                        input logic pb);
    if (PARITY_EN == 0) return 1'b0;
    return ((^d) ^ pb) != 1'(PARITY_ODD);
  endfunction

  // Next-state and sample-point decode. finish (the clk after the mid-stop
  // sample) returns to IDLE regardless of rx_tick.
  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    cnt_inc   = 1'b0;
    if (finish) begin
      state_nx = IDLE;
    end else if (rx_tick) begin
      unique case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_nx  = START;
            start_det = 1'b1;
          end
        end
        START: begin
          if (cnt == half_m1) state_nx = rx_s ? IDLE : DATA;
          else                cnt_inc  = 1'b1;
        end
        DATA: begin
          if (cnt == full_m1) begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        PARITY: begin
          if (cnt == full_m1) begin
            par_en   = 1'b1;
            state_nx = STOP;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        STOP: begin
          if (cnt == full_m1) stop_en = 1'b1;
          else                cnt_inc = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
    // Every sample point restarts the bit-period count, as does any state change.
    cnt_clr = (state_nx != state) || shift_en || stop_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      primed      <= 2'b00;
      state       <= IDLE;
      cnt         <= 8'd0;
      p_lat       <= 8'd0;
      bit_cnt     <= 3'd0;
      armed       <= 1'b0;
      finish      <= 1'b0;
      shift       <= '0;
      par_bit     <= 1'b0;
      stop_bit    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_m       <= rx_in;
      rx_s       <= rx_m;
      // The synchronizer resets high, so its first two outputs after reset are
      // not real line observations and must not arm start detection.
      primed     <= {primed[0], 1'b1};
      state      <= state_nx;
      finish     <= stop_en;
      data_valid <= 1'b0;

      if (cnt_clr)      cnt <= 8'd0;
      else if (cnt_inc) cnt <= cnt + 8'd1;

      if (start_det) begin
        p_lat   <= prescale;
        bit_cnt <= 3'd0;
        armed   <= 1'b0;
      end else if (finish) begin
        // A low stop bit (break / framing error) keeps detection disarmed
        // until the line is seen high again.
        armed <= stop_bit;
      end else if (rx_tick && state == IDLE && rx_s && primed[1]) begin
        armed <= 1'b1;
      end

      if (shift_en) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en)  par_bit  <= rx_s;
      if (stop_en) stop_bit <= rx_s;

      if (finish) begin
        data_valid  <= 1'b1;
        data_out    <= shift;
        framing_err <= ~stop_bit;
        parity_err  <= parity_check(shift, par_bit);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled
//   Directed bench for uart_rx_oversampled. Instance u_a is 8N1, instance u_p
//   is 8E1; each has its own serial line and they share clk, rst, rx_tick and
//   prescale. Delivered frames are captured into queues at the falling edge.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_tick = 1'b0;
  logic [7:0] prescale = 8'd16;
  logic       rxa = 1'b1;
  logic       rxp = 1'b1;

  logic [7:0] data_a, data_p;
  logic       dv_a, dv_p, perr_a, perr_p, ferr_a, ferr_p, busy_a, busy_p;

  int         checks = 0;
  int         failures = 0;
  int         tick_div = 1;
  int         phase = 0;
  longint     cyc = 0;

  logic [7:0] qa_data[$];
  logic       qa_perr[$];
  logic       qa_ferr[$];
  longint     qa_cyc[$];
  logic [7:0] qp_data[$];
  logic       qp_perr[$];
  logic       qp_ferr[$];

  uart_rx_oversampled #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_a (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .prescale(prescale), .rx_in(rxa),
    .data_out(data_a), .data_valid(dv_a), .parity_err(perr_a),
    .framing_err(ferr_a), .busy(busy_a)
  );

  uart_rx_oversampled #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_p (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .prescale(prescale), .rx_in(rxp),
    .data_out(data_p), .data_valid(dv_p), .parity_err(perr_p),
    .framing_err(ferr_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // rx_tick changes only on the falling edge: high once every tick_div clks.
  initial begin
    forever begin
      @(negedge clk);
      if (phase >= tick_div - 1) begin
        phase   = 0;
        rx_tick = 1'b1;
      end else begin
        phase   = phase + 1;
        rx_tick = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (dv_a) begin
      qa_data.push_back(data_a);
      qa_perr.push_back(perr_a);
      qa_ferr.push_back(ferr_a);
      qa_cyc.push_back(cyc);
    end
    if (dv_p) begin
      qp_data.push_back(data_p);
      qp_perr.push_back(perr_p);
      qp_ferr.push_back(ferr_p);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Returns on the rising edge of the n-th tick.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
  endtask

  // Called on a falling edge; drives one bit for a full bit period and
  // returns on the falling edge where the next bit should start.
  task automatic send_bit(input bit sel, input logic b);
    if (sel) rxp = b;
    else     rxa = b;
    wait_ticks(int'(prescale));
    @(negedge clk);
  endtask

  // Leaves the line at the stop value; the caller restores idle.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (has_par) send_bit(sel, par);
    send_bit(sel, stop);
  endtask

  task automatic idle(input int n);
    rxa = 1'b1;
    rxp = 1'b1;
    wait_ticks(n);
    @(negedge clk);
  endtask

  int n0, np0;

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data",  data_a, 8'h00);
    check_eq("rst_valid", dv_a,   1'b0);
    check_eq("rst_perr",  perr_a, 1'b0);
    check_eq("rst_ferr",  ferr_a, 1'b0);
    check_eq("rst_busy",  busy_a, 1'b0);
    rst = 1'b1;
    idle(20);

    // 0xA5 8N1, prescale 16, tick every clk
    n0 = qa_data.size();
    check_eq("a5_busy_pre", busy_a, 1'b0);
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        wait_ticks(40);
        @(negedge clk);
        check_eq("a5_busy_mid", busy_a, 1'b1);
      end
    join
    idle(20);
    check_eq("a5_count", qa_data.size(), n0 + 1);
    check_eq("a5_data",  qa_data[$], 8'hA5);
    check_eq("a5_perr",  qa_perr[$], 1'b0);
    check_eq("a5_ferr",  qa_ferr[$], 1'b0);
    check_eq("a5_busy_post", busy_a, 1'b0);

    // Glitch: low for 4 ticks only, then a good 0x3C
    n0 = qa_data.size();
    rxa = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    idle(30);
    check_eq("glitch_count", qa_data.size(), n0);
    check_eq("glitch_busy",  busy_a, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(20);
    check_eq("3c_count", qa_data.size(), n0 + 1);
    check_eq("3c_data",  qa_data[$], 8'h3C);
    check_eq("3c_ferr",  qa_ferr[$], 1'b0);

    // Framing error, then line held low, then a good 0x55
    n0 = qa_data.size();
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    rxa = 1'b0;
    wait_ticks(40);
    @(negedge clk);
    check_eq("fe_count", qa_data.size(), n0 + 1);
    check_eq("fe_data",  qa_data[$], 8'h81);
    check_eq("fe_ferr",  qa_ferr[$], 1'b1);
    idle(20);
    check_eq("fe_no_spurious", qa_data.size(), n0 + 1);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    idle(20);
    check_eq("55_count", qa_data.size(), n0 + 2);
    check_eq("55_data",  qa_data[$], 8'h55);
    check_eq("55_ferr",  qa_ferr[$], 1'b0);

    // Parity (8E1 instance): 0x07 has three ones
    np0 = qp_data.size();
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(20);
    check_eq("par_count", qp_data.size(), np0 + 2);
    check_eq("par1_data", qp_data[np0],     8'h07);
    check_eq("par1_perr", qp_perr[np0],     1'b0);
    check_eq("par2_data", qp_data[np0 + 1], 8'h07);
    check_eq("par2_perr", qp_perr[np0 + 1], 1'b1);
    check_eq("par2_ferr", qp_ferr[np0 + 1], 1'b0);

    // Back-to-back 0x00 / 0xFF, prescale 8, tick every 3 clk
    prescale = 8'd8;
    tick_div = 3;
    idle(10);
    n0 = qa_data.size();
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    idle(20);
    check_eq("b2b_count", qa_data.size(), n0 + 2);
    check_eq("b2b_data0", qa_data[n0],     8'h00);
    check_eq("b2b_data1", qa_data[n0 + 1], 8'hFF);
    check_eq("b2b_gap",   32'(qa_cyc[n0 + 1] - qa_cyc[n0]), 32'd240);

    // Reset during data bit 3 of 0xC3
    prescale = 8'd16;
    tick_div = 1;
    idle(10);
    n0 = qa_data.size();
    fork
      send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
      begin
        wait_ticks(16 + 3 * 16 + 8);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("mrst_data",  data_a, 8'h00);
        check_eq("mrst_busy",  busy_a, 1'b0);
        check_eq("mrst_ferr",  ferr_a, 1'b0);
        check_eq("mrst_valid", dv_a,   1'b0);
      end
    join
    idle(40);
    check_eq("mrst_no_valid", qa_data.size(), n0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    idle(20);
    check_eq("5a_count", qa_data.size(), n0 + 1);
    check_eq("5a_data",  qa_data[$], 8'h5A);
    check_eq("5a_ferr",  qa_ferr[$], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
